// File: rtl/layer_sched_pkg.sv
// Shared types and defaults for the layer scheduler: FSM state encoding,
// the default-width descriptor record and a counter-width helper.
package layer_sched_pkg;

  localparam int DATA_CWIDTH_DEF = 32;
  localparam int WICP_CWIDTH_DEF = 32;
  localparam int TMPC_CWIDTH_DEF = 32;
  localparam int POST_CWIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_CWIDTH_DEF-1:0] data;
    logic [WICP_CWIDTH_DEF-1:0] wicp;
    logic [TMPC_CWIDTH_DEF-1:0] tmpc;
    logic [POST_CWIDTH_DEF-1:0] post;
  } desc_t;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Host descriptor handshake plus the config handshake toward the PE-array core.
// The scheduler uses the slave view; the host/core environment uses master.
interface layer_sched_if
  import layer_sched_pkg::*;
#(
  parameter int DATA_CWIDTH = DATA_CWIDTH_DEF,
  parameter int WICP_CWIDTH = WICP_CWIDTH_DEF,
  parameter int TMPC_CWIDTH = TMPC_CWIDTH_DEF,
  parameter int POST_CWIDTH = POST_CWIDTH_DEF
);

  logic                   host_valid;
  logic                   host_ready;
  logic [DATA_CWIDTH-1:0] host_data;
  logic [WICP_CWIDTH-1:0] host_wicp;
  logic [TMPC_CWIDTH-1:0] host_tmpc;
  logic [POST_CWIDTH-1:0] host_post;

  logic                   cfg_valid;
  logic                   cfg_busy;
  logic [DATA_CWIDTH-1:0] cfg_data_data;
  logic [WICP_CWIDTH-1:0] cfg_wicp_data;
  logic [TMPC_CWIDTH-1:0] cfg_tmpc_data;
  logic [POST_CWIDTH-1:0] cfg_post_data;

  modport slave (
    input  host_valid, host_data, host_wicp, host_tmpc, host_post, cfg_busy,
    output host_ready, cfg_valid, cfg_data_data, cfg_wicp_data, cfg_tmpc_data,
           cfg_post_data
  );

  modport master (
    output host_valid, host_data, host_wicp, host_tmpc, host_post, cfg_busy,
    input  host_ready, cfg_valid, cfg_data_data, cfg_wicp_data, cfg_tmpc_data,
           cfg_post_data
  );

endinterface

// File: rtl/layer_sched_fifo.sv
// Synchronous single-clock descriptor FIFO with full/empty flags.
// Pointers carry one wrap bit so full and empty are distinguishable.
module cfg_desc_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push while full is dropped even if a pop frees a slot the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: queues host descriptors and hands them one at a time to the
// PE-array core, tracking completion, layer count and handshake timeout.
module layer_sched
  import layer_sched_pkg::*;
#(
  parameter int DATA_CWIDTH = DATA_CWIDTH_DEF,
  parameter int WICP_CWIDTH = WICP_CWIDTH_DEF,
  parameter int TMPC_CWIDTH = TMPC_CWIDTH_DEF,
  parameter int POST_CWIDTH = POST_CWIDTH_DEF,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst,
  layer_sched_if.slave       bus,
  input  logic               run_en,
  output logic               layer_done,
  output logic [15:0]        layer_cnt,
  output logic               idle,
  output logic               err_timeout
);

  localparam int DW       = DATA_CWIDTH + WICP_CWIDTH + TMPC_CWIDTH + POST_CWIDTH;
  localparam int POST_LSB = 0;
  localparam int TMPC_LSB = POST_LSB + POST_CWIDTH;
  localparam int WICP_LSB = TMPC_LSB + TMPC_CWIDTH;
  localparam int DATA_LSB = WICP_LSB + WICP_CWIDTH;
  localparam int WAIT_W   = cnt_width(TIMEOUT);

  state_e            state;
  state_e            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_hit;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DW-1:0]     fifo_din;
  logic [DW-1:0]     fifo_head;

  logic              load_cfg;
  logic              finish;
  logic              timeout_hit;

  logic                   cfg_valid_q;
  logic [DATA_CWIDTH-1:0] cfg_data_q;
  logic [WICP_CWIDTH-1:0] cfg_wicp_q;
  logic [TMPC_CWIDTH-1:0] cfg_tmpc_q;
  logic [POST_CWIDTH-1:0] cfg_post_q;
  logic                   layer_done_q;
  logic [15:0]            layer_cnt_q;
  logic                   err_q;

  assign fifo_din  = {bus.host_data, bus.host_wicp, bus.host_tmpc, bus.host_post};
  assign fifo_push = bus.host_valid && bus.host_ready;

  cfg_desc_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  assign wait_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (run_en && !fifo_empty && !bus.cfg_busy) next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (bus.cfg_busy)  next_state = ST_RUN;
        else if (wait_hit) next_state = ST_ERR;
      end
      ST_RUN:   if (!bus.cfg_busy) next_state = ST_IDLE;
      ST_ERR:   next_state = ST_ERR;
      default:  next_state = ST_IDLE;
    endcase
  end

  // NOTE: every strobe gets a default before the case so no latch is inferred.
  always_comb begin
    load_cfg    = 1'b0;
    fifo_pop    = 1'b0;
    finish      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:  load_cfg    = (next_state == ST_ISSUE);
      ST_ISSUE: begin
        fifo_pop    = bus.cfg_busy;
        timeout_hit = (next_state == ST_ERR);
      end
      ST_RUN:   finish      = !bus.cfg_busy;
      default:  ;
    endcase
  end

  // The head stays in the FIFO until the core accepts it, so fields are stable in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_valid_q  <= 1'b0;
      cfg_data_q   <= '0;
      cfg_wicp_q   <= '0;
      cfg_tmpc_q   <= '0;
      cfg_post_q   <= '0;
      layer_done_q <= 1'b0;
      layer_cnt_q  <= '0;
      err_q        <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      cfg_valid_q  <= (next_state == ST_ISSUE);
      layer_done_q <= finish;
      if (finish)      layer_cnt_q <= layer_cnt_q + 16'd1;
      if (timeout_hit) err_q       <= 1'b1;
      wait_cnt <= (state == ST_ISSUE && next_state == ST_ISSUE) ? wait_cnt + 1'b1 : '0;
      if (load_cfg) begin
        cfg_data_q <= fifo_head[DATA_LSB +: DATA_CWIDTH];
        cfg_wicp_q <= fifo_head[WICP_LSB +: WICP_CWIDTH];
        cfg_tmpc_q <= fifo_head[TMPC_LSB +: TMPC_CWIDTH];
        cfg_post_q <= fifo_head[POST_LSB +: POST_CWIDTH];
      end
    end
  end

  assign bus.host_ready    = !fifo_full && (state != ST_ERR);
  assign bus.cfg_valid     = cfg_valid_q;
  assign bus.cfg_data_data = cfg_data_q;
  assign bus.cfg_wicp_data = cfg_wicp_q;
  assign bus.cfg_tmpc_data = cfg_tmpc_q;
  assign bus.cfg_post_data = cfg_post_q;

  assign layer_done  = layer_done_q;
  assign layer_cnt   = layer_cnt_q;
  assign err_timeout = err_q;
  assign idle        = (state == ST_IDLE) && fifo_empty;

endmodule
